tr_manual_step_sequencer: RTL and testbench
===========================================

// Module: tr_manual_step_sequencer
// PURPOSE
//  Manual-mode step/direction pulse sequencer for the TR drive. Consumes the one-cycle command
//  strobes (stop/start/start_N) and the period, pulse-count, direction and count-enable settings
//  from the Avalon command/parameter register block. Drives the step/dir outputs to the motor
//  driver and reports busy, done and the emitted-pulse count for readback.
// PARAMETERS
//  WIDTH_TP       32  width of period, pulse-number and pulse-count values
//  DIR_SETUP_CYC  4   clk cycles dir_out is held stable before the first step edge (>=1)
//  MIN_PERIOD     2   smallest period used; a smaller period_MANUAL is clamped to this value
// PORTS
//  clk            in   1         50 MHz system clock
//  rst            in   1         asynchronous, active-low reset
//  start          in   1         1-cycle strobe: continuous stepping
//  start_N        in   1         1-cycle strobe: emit PULSE_NUMBER steps
//  stop           in   1         1-cycle strobe: abort, outputs idle
//  period_MANUAL  in   WIDTH_TP  step period in clk cycles
//  PULSE_NUMBER   in   WIDTH_TP  pulse count for start_N
//  dir_MANUAL     in   1         requested direction (bit 0 used)
//  count_MANUAL   in   1         enables pulse_count increments
//  step           out  1         step pulse to driver
//  dir_out        out  1         direction to driver
//  busy           out  1         1 in any state other than IDLE
//  done           out  1         1-cycle pulse when a start_N run completes
//  pulse_count    out  WIDTH_TP  emitted steps since last accepted start, wraps modulo 2^WIDTH_TP
// BEHAVIOUR
//  Reset: step=0, dir_out=0, busy=0, done=0, pulse_count=0, state=IDLE; applies mid-run at once.
//  FSM states: IDLE, SETUP, HIGH, LOW.
//  - IDLE: accepted strobe -> SETUP; latch mode (CONT/N), dir_out<=dir_MANUAL, N<=PULSE_NUMBER,
//    pulse_count<=0.
//  - SETUP: DIR_SETUP_CYC cycles -> HIGH. Strobe at edge k: dir_out at k+1, step rises at
//    k+1+DIR_SETUP_CYC.
//  - Period P is sampled on entry to each HIGH (clamp to MIN_PERIOD). HIGH = P>>1 cycles,
//    LOW = P-(P>>1) cycles. Changes to period_MANUAL take effect at the next step edge.
//  - On the step rising edge, pulse_count increments if count_MANUAL=1. The remaining count
//    decrements whether or not count_MANUAL is set.
//  - LOW end: CONT -> HIGH. N mode with remaining=0 -> IDLE with done=1 for that one cycle.
//  - start_N with PULSE_NUMBER=0: no SETUP and no step; done=1 on the next cycle; dir_out is
//    still updated.
//  Priority of simultaneous strobes: stop > start_N > start.
//  start/start_N are ignored while busy. dir_MANUAL changes are ignored while busy.
//  stop in any busy state: step<=0 next edge, state->IDLE, done stays 0, pulse_count is held.
//  A stop in IDLE has no effect.
// STRUCTURE
//  Shared package tr_pkg: state enum, WIDTH_TP, MIN_PERIOD, mode encoding.
//  Sub-module tr_phase_timer: loadable down-counter with load value/load/expire, used for SETUP,
//  HIGH and LOW. The FSM, pulse counter and remaining counter live in the top level.
// TESTING
//  1 P=10, N=3, DIR_SETUP=4, strobe start_N@0 -> dir@1; step rises @5, 15, 25 (5 high/5 low);
//    done@35; pulse_count=3; busy 1..34.
//  2 start, P=7 -> high 3/low 4 repeating. P changed to 4 mid-HIGH -> current period finishes
//    at 7, next is 2/2. stop mid-HIGH -> step=0 next cycle, done=0, count held.
//  3 start_N with N=0 -> no step, done 1 cycle later, busy never 1. P=0 or 1 -> behaves as P=2 (1/1).
//  4 stop+start_N+start same cycle in IDLE -> stays IDLE. start_N+start -> N mode.
//    start while busy -> ignored.
//  5 count_MANUAL=0, N=5 -> 5 steps, pulse_count=0, done fires. Preload pulse_count near
//    2^WIDTH_TP-1 via small WIDTH_TP=4 and 20 steps -> wraps to 4.
//  6 rst low during HIGH -> step=0, busy=0 immediately (async). Release -> IDLE, all outputs 0.

Source files
------------

// File: rtl/tr_pkg.sv
// tr_pkg: shared types and default settings for the TR manual step sequencer
package tr_pkg;
  localparam int TR_WIDTH_TP = 32;
  localparam int TR_DIR_SETUP_CYC = 4;
  localparam int TR_MIN_PERIOD = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} state_e;
  typedef enum logic {MODE_CONT, MODE_N} mode_e;
endpackage

// File: rtl/tr_phase_timer.sv
// tr_phase_timer: loadable down-counter whose expire marks the last cycle of a loaded phase
module tr_phase_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expire = cnt == W'(1);
endmodule

// File: rtl/tr_manual_step_sequencer.sv
// tr_manual_step_sequencer: manual-mode step/dir pulse generator with continuous and N-step runs
module tr_manual_step_sequencer import tr_pkg::*; #(
  parameter int WIDTH_TP = TR_WIDTH_TP,
  parameter int DIR_SETUP_CYC = TR_DIR_SETUP_CYC,
  parameter int MIN_PERIOD = TR_MIN_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                start_N,
  input  logic                stop,
  input  logic [WIDTH_TP-1:0] period_MANUAL,
  input  logic [WIDTH_TP-1:0] PULSE_NUMBER,
  input  logic                dir_MANUAL,
  input  logic                count_MANUAL,
  output logic                step,
  output logic                dir_out,
  output logic                busy,
  output logic                done,
  output logic [WIDTH_TP-1:0] pulse_count
);
  state_e state, next;
  mode_e mode;
  logic [WIDTH_TP-1:0] remaining, low_len, period, load_value;
  logic accept, zero_run, finish, rise, load, expire;
  assign period = period_MANUAL < WIDTH_TP'(MIN_PERIOD) ? WIDTH_TP'(MIN_PERIOD) : period_MANUAL;
  assign accept = state == ST_IDLE && !stop && (start || start_N);
  assign zero_run = accept && start_N && PULSE_NUMBER == '0;
  assign finish = state == ST_LOW && !stop && expire && mode == MODE_N && remaining == '0;
  assign rise = next == ST_HIGH && state != ST_HIGH;
  assign load = next != state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state != ST_IDLE && stop) next = ST_IDLE;
    else if (accept) next = zero_run ? ST_IDLE : ST_SETUP;
    else if (state != ST_IDLE && expire)
      next = state == ST_SETUP ? ST_HIGH : state == ST_HIGH ? ST_LOW : finish ? ST_IDLE : ST_HIGH;
  end
  always_comb begin
    step = state == ST_HIGH;
    busy = state != ST_IDLE;
  end
  // LOW length comes from the period latched at the rising edge, not the live input
  always_comb begin
    load_value = next == ST_SETUP ? WIDTH_TP'(DIR_SETUP_CYC) : next == ST_HIGH ? period >> 1 : low_len;
  end
  tr_phase_timer #(.W(WIDTH_TP)) u_timer (
    .clk(clk), .rst(rst), .load(load), .value(load_value), .expire(expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dir_out <= 1'b0;
      done <= 1'b0;
      mode <= MODE_CONT;
      remaining <= '0;
      low_len <= '0;
      pulse_count <= '0;
    end else begin
      done <= zero_run || finish;
      if (accept) begin
        dir_out <= dir_MANUAL;
        mode <= start_N ? MODE_N : MODE_CONT;
        remaining <= PULSE_NUMBER;
        pulse_count <= '0;
      end
      if (rise) begin
        remaining <= remaining - 1'b1;
        low_len <= period - (period >> 1);
        if (count_MANUAL) pulse_count <= pulse_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_tr_manual_step_sequencer.sv
// tb_tr_manual_step_sequencer: scenario tasks plus randomized traffic against a timeline reference model
module tb_tr_manual_step_sequencer;
  localparam int W = 32;
  localparam int DS = 4;
  logic clk = 0, rst = 0;
  logic start = 0, start_N = 0, stop = 0, dir_MANUAL = 0, count_MANUAL = 1;
  logic [W-1:0] period_MANUAL = 10, PULSE_NUMBER = 0;
  logic step, dir_out, busy, done;
  logic [W-1:0] pulse_count;
  logic start4 = 0, stop4 = 0, step4, dir4, busy4, done4;
  logic [3:0] period4 = 2, count4;
  int checks = 0, failures = 0;
  bit m_busy, m_mode_n, m_dir, m_done;
  logic [W-1:0] m_left, m_count;
  longint cnum = 0, m_rise = 0, m_fall = 0;
  logic [W+3:0] expv, obs;
  assign obs = {step, dir_out, busy, done, pulse_count};
  always #5 clk = ~clk;

  tr_manual_step_sequencer #(.WIDTH_TP(W), .DIR_SETUP_CYC(DS), .MIN_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .start(start), .start_N(start_N), .stop(stop),
    .period_MANUAL(period_MANUAL), .PULSE_NUMBER(PULSE_NUMBER), .dir_MANUAL(dir_MANUAL),
    .count_MANUAL(count_MANUAL), .step(step), .dir_out(dir_out), .busy(busy), .done(done),
    .pulse_count(pulse_count)
  );
  tr_manual_step_sequencer #(.WIDTH_TP(4), .DIR_SETUP_CYC(DS), .MIN_PERIOD(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .start_N(1'b0), .stop(stop4),
    .period_MANUAL(period4), .PULSE_NUMBER(4'd0), .dir_MANUAL(1'b1),
    .count_MANUAL(1'b1), .step(step4), .dir_out(dir4), .busy(busy4), .done(done4),
    .pulse_count(count4)
  );

  task automatic model_reset();
    m_busy = 0; m_mode_n = 0; m_dir = 0; m_done = 0;
    m_left = '0; m_count = '0; m_rise = 0; m_fall = 0; expv = '0;
  endtask

  // Absolute-time view: each run is a schedule of rise times and fall times
  task automatic model_edge();
    longint p;
    cnum++;
    m_done = 0;
    if (!m_busy) begin
      if (!stop && (start || start_N)) begin
        m_dir = dir_MANUAL;
        m_count = '0;
        if (start_N && PULSE_NUMBER == 0) m_done = 1;
        else begin
          m_busy = 1; m_mode_n = start_N; m_left = PULSE_NUMBER;
          m_rise = cnum + DS; m_fall = cnum;
        end
      end
    end else if (stop) m_busy = 0;
    else if (cnum == m_rise) begin
      if (m_mode_n && m_left == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        p = (period_MANUAL < 2) ? 2 : longint'(period_MANUAL);
        m_fall = cnum + p / 2;
        m_rise = cnum + p;
        m_left--;
        if (count_MANUAL) m_count++;
      end
    end
    expv = {m_busy && (cnum < m_fall), m_dir, m_busy, m_done, m_count};
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; start_N = 0; stop = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_hold got %h want 0", obs); end
    @(negedge clk);
    rst = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL reset_idle i=%0d got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_n_run();
    int rises[$];
    int done_at = -1;
    logic prev = 0;
    period_MANUAL = 10; PULSE_NUMBER = 3; dir_MANUAL = 1; count_MANUAL = 1;
    start_N = 1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL n_run cycle=%0d got %h want %h", i, obs, expv); end
      if (step && !prev) rises.push_back(i);
      if (done) done_at = i;
      prev = step;
    end
    checks++;
    if (rises.size() != 3 || rises[0] != 5 || rises[1] != 15 || rises[2] != 25) begin
      failures++; $display("FAIL n_run_rises got n=%0d want rises at 5,15,25", rises.size());
    end
    checks++;
    if (done_at != 35 || pulse_count !== 32'd3) begin
      failures++; $display("FAIL n_run_done got done@%0d count=%0d want done@35 count=3", done_at, pulse_count);
    end
  endtask

  task automatic test_cont_period();
    period_MANUAL = 7; dir_MANUAL = 0; count_MANUAL = 1;
    start = 1;
    for (int i = 1; i <= 26; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL cont cycle=%0d got %h want %h", i, obs, expv); end
      if (i == 13) period_MANUAL = 4;
      if (i == 19) stop = 1;
    end
    checks++;
    if ({busy, step, done, pulse_count} !== {3'b000, 32'd3}) begin
      failures++; $display("FAIL cont_stop got busy=%b step=%b count=%0d want 0,0,3", busy, step, pulse_count);
    end
  endtask

  task automatic test_zero_small();
    bit saw_busy = 0;
    int done_at = -1;
    PULSE_NUMBER = 0; dir_MANUAL = 1;
    start_N = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL zero_n cycle=%0d got %h want %h", i, obs, expv); end
      if (busy) saw_busy = 1;
      if (done) done_at = i;
    end
    checks++;
    if (saw_busy || done_at != 1 || dir_out !== 1'b1) begin
      failures++; $display("FAIL zero_n_summary got busy_seen=%0d done@%0d dir=%b want 0,1,1", saw_busy, done_at, dir_out);
    end
    for (int k = 0; k < 2; k++) begin
      period_MANUAL = W'(k); PULSE_NUMBER = 3;
      start_N = 1;
      for (int i = 1; i <= 16; i++) begin
        cyc();
        checks++;
        if (obs !== expv) begin failures++; $display("FAIL small_p%0d cycle=%0d got %h want %h", k, i, obs, expv); end
      end
    end
  endtask

  task automatic test_priority();
    int rises = 0;
    bit saw_done = 0;
    logic prev = 0;
    period_MANUAL = 4; PULSE_NUMBER = 2;
    stop = 1; start = 1; start_N = 1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (obs !== expv || busy) begin failures++; $display("FAIL prio_stop cycle=%0d got %h want %h", i, obs, expv); end
    end
    start = 1; start_N = 1;
    for (int i = 1; i <= 18; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL prio_n cycle=%0d got %h want %h", i, obs, expv); end
      if (step && !prev) rises++;
      if (done) saw_done = 1;
      prev = step;
    end
    checks++;
    if (rises != 2 || !saw_done) begin failures++; $display("FAIL prio_n_mode got rises=%0d done=%0d want 2,1", rises, saw_done); end
    start = 1; dir_MANUAL = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL busy_ignore cycle=%0d got %h want %h", i, obs, expv); end
      if (i == 8) begin start_N = 1; PULSE_NUMBER = 1; dir_MANUAL = 1; end
      if (i == 12) start = 1;
      if (i == 19) stop = 1;
    end
  endtask

  task automatic test_no_count();
    int rises = 0, n = 0;
    logic prev = 0;
    period_MANUAL = 3; PULSE_NUMBER = 5; count_MANUAL = 0;
    start_N = 1;
    do begin
      cyc();
      n++;
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL no_count cycle=%0d got %h want %h", n, obs, expv); end
      if (step && !prev) rises++;
      prev = step;
    end while (!done && n < 60);
    checks++;
    if (!done || rises != 5 || pulse_count !== '0) begin
      failures++; $display("FAIL no_count_summary got done=%b rises=%0d count=%0d want 1,5,0", done, rises, pulse_count);
    end
    count_MANUAL = 1;
  endtask

  task automatic test_wrap();
    int rises = 0, n = 0;
    logic prev = 0;
    period4 = 2;
    start4 = 1;
    @(posedge clk);
    #1 start4 = 0;
    while (rises < 20 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (step4 && !prev) begin
        rises++;
        if (rises == 16) begin
          checks++;
          if (count4 !== 4'd0) begin failures++; $display("FAIL wrap16 got %0d want 0", count4); end
        end
      end
      prev = step4;
    end
    checks++;
    if (rises < 20 || count4 !== 4'd4) begin failures++; $display("FAIL wrap20 got rises=%0d count=%0d want 20,4", rises, count4); end
    stop4 = 1;
    @(posedge clk);
    #1 stop4 = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy4, step4, done4, count4} !== {3'b000, 4'd4}) begin
      failures++; $display("FAIL wrap_stop got busy=%b step=%b count=%0d want 0,0,4", busy4, step4, count4);
    end
  endtask

  task automatic test_async_reset();
    period_MANUAL = 10; dir_MANUAL = 1;
    start = 1;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL pre_reset cycle=%0d got %h want %h", i, obs, expv); end
    end
    #3 rst = 0;
    #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL async_reset got %h want 0", obs); end
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL post_reset cycle=%0d got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 16) == 0;
      start_N = ($urandom % 16) == 0;
      stop = ($urandom % 50) == 0;
      dir_MANUAL = $urandom % 2;
      count_MANUAL = ($urandom % 4) != 0;
      PULSE_NUMBER = $urandom_range(0, 4);
      if ($urandom % 8 == 0) period_MANUAL = $urandom_range(0, 9);
      cyc();
      checks++;
      if (obs !== expv) begin failures++; $display("FAIL random i=%0d got %h want %h", i, obs, expv); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_n_run();
    test_cont_period();
    test_zero_small();
    test_priority();
    test_no_count();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
